// File: rtl/dds_pkg.sv
// Shared DDFS definitions: octant encoding and dither LFSR constants.
// Used by phase_octant_fold, the sin/cos core and the octant antitransform.
package dds_pkg;

  localparam int OCT_W = 3;

  typedef enum logic [OCT_W-1:0] {
    OCT_0 = 3'd0,
    OCT_1 = 3'd1,
    OCT_2 = 3'd2,
    OCT_3 = 3'd3,
    OCT_4 = 3'd4,
    OCT_5 = 3'd5,
    OCT_6 = 3'd6,
    OCT_7 = 3'd7
  } oct_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/octant_delay_line.sv
// Resettable DEPTH-stage shift register; carries {valid, octant} alongside
// the sin/cos core so the antitransform sees a matching octant.
module octant_delay_line #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/phase_octant_fold.sv
// DDFS front end: phase accumulator, octant fold and latency-matched octant delay.
// Optional phase dither on the truncated bits when PHASE_DITHER_EN is defined.
module phase_octant_fold
  import dds_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int FOLD_W   = 17,
  parameter int CORE_LAT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic [ACC_W-1:0]  fcw,
  input  logic              fcw_wr,
  output logic              fold_valid,
  output logic [FOLD_W-1:0] fold_ang,
  output logic [OCT_W-1:0]  fold_oct,
  output logic [OCT_W-1:0]  phi_r,
  output logic              phi_r_valid
);

  localparam int TRUNC_W = ACC_W - OCT_W - FOLD_W;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  fcw_q;
  logic [ACC_W-1:0]  acc_s;
  logic              sample;
  logic [OCT_W-1:0]  oct;
  logic [FOLD_W-1:0] r;

  assign sample = en & ~phase_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      fcw_q <= '0;
    end else begin
      if (phase_clr) acc <= '0;
      else if (en)   acc <= acc + fcw_q;
      if (fcw_wr) fcw_q <= fcw;
    end
  end

`ifdef PHASE_DITHER_EN
  localparam int DITH_W = (TRUNC_W < 16) ? TRUNC_W : 16;
  localparam logic [ACC_W-1:0] DITH_MASK = ACC_W'((64'(1) << DITH_W) - 64'(1));

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)         lfsr <= LFSR_SEED;
    else if (sample) lfsr <= lfsr_step(lfsr);
  end

  // carry out of the dither add may ripple into r and oct
  assign acc_s = acc + (ACC_W'(lfsr) & DITH_MASK);
`else
  assign acc_s = acc;
`endif

  assign oct = acc_s[ACC_W-1 -: OCT_W];
  assign r   = FOLD_W'(acc_s >> TRUNC_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      fold_valid <= 1'b0;
      fold_ang   <= '0;
      fold_oct   <= '0;
    end else begin
      fold_valid <= sample;
      if (sample) begin
        fold_oct <= oct;
        fold_ang <= oct[0] ? ~r : r;
      end
    end
  end

  // fold_oct holds during bubbles, so phi_r naturally keeps the last valid octant
  octant_delay_line #(
    .DEPTH (CORE_LAT),
    .W     (OCT_W + 1)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({fold_valid, fold_oct}),
    .q   ({phi_r_valid, phi_r})
  );

endmodule

// File: tb/tb_phase_octant_fold.sv
// Self-checking bench for phase_octant_fold: directed scenarios plus random traffic
// against a cycle-level behavioural model (PHASE_DITHER_EN optional).
module tb_phase_octant_fold;

  localparam int ACC_W    = 32;
  localparam int FOLD_W   = 17;
  localparam int CORE_LAT = 16;

  logic              clk = 1'b0;
  logic              rst, en, phase_clr, fcw_wr;
  logic [ACC_W-1:0]  fcw;
  logic              fold_valid, phi_r_valid;
  logic [FOLD_W-1:0] fold_ang;
  logic [2:0]        fold_oct, phi_r;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_acc, m_fcw;
  logic        m_fv;
  logic [16:0] m_ang;
  logic [2:0]  m_oct;
  logic [15:0] m_lfsr;
  logic [3:0]  hist [$];

  phase_octant_fold #(
    .ACC_W    (ACC_W),
    .FOLD_W   (FOLD_W),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_clr   (phase_clr),
    .fcw         (fcw),
    .fcw_wr      (fcw_wr),
    .fold_valid  (fold_valid),
    .fold_ang    (fold_ang),
    .fold_oct    (fold_oct),
    .phi_r       (phi_r),
    .phi_r_valid (phi_r_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock of the reference: phase as an integer mod 2^32, history queue for phi_r
  task automatic model_edge(input logic r, input logic e, input logic c,
                            input logic w, input logic [31:0] f);
    logic [31:0] a;
    logic [16:0] rr;
    if (r) begin
      m_acc = 0; m_fcw = 0; m_fv = 0; m_ang = 0; m_oct = 0; m_lfsr = 16'hACE1;
      hist.delete();
      for (int i = 0; i <= CORE_LAT; i++) hist.push_back(4'h0);
    end else begin
      m_fv = e & ~c;
      if (m_fv) begin
        a = m_acc;
`ifdef PHASE_DITHER_EN
        a = a + {20'h0, m_lfsr[11:0]};
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        m_oct = a[31:29];
        rr    = a[28:12];
        m_ang = m_oct[0] ? ~rr : rr;
      end
      if (c)      m_acc = 0;
      else if (e) m_acc = m_acc + m_fcw;
      if (w) m_fcw = f;
      hist.push_back({m_fv, m_oct});
      while (hist.size() > CORE_LAT + 1) void'(hist.pop_front());
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic c,
                     input logic w, input logic [31:0] f);
    logic [3:0] h;
    rst = r; en = e; phase_clr = c; fcw_wr = w; fcw = f;
    @(posedge clk);
    model_edge(r, e, c, w, f);
    #1;
    h = hist[0];
    chk("fold_valid",  32'(fold_valid),  32'(m_fv));
    chk("fold_ang",    32'(fold_ang),    32'(m_ang));
    chk("fold_oct",    32'(fold_oct),    32'(m_oct));
    chk("phi_r_valid", 32'(phi_r_valid), 32'(h[3]));
    chk("phi_r",       32'(phi_r),       32'(h[2:0]));
  endtask

  initial begin
    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_fold_valid", 32'(fold_valid), 0);
    chk("rst_phi_r_valid", 32'(phi_r_valid), 0);

    // eighth-turn steps walk all octants
    cyc(0, 0, 0, 1, 32'h2000_0000);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 0, 0);
`ifndef PHASE_DITHER_EN
      chk("t1_oct", 32'(fold_oct), 32'(i % 8));
      chk("t1_ang", 32'(fold_ang), (i % 2 == 1) ? 32'h1FFFF : 32'h0);
`endif
    end
    for (int i = 0; i < CORE_LAT + 2; i++) cyc(0, 0, 0, 0, 0);

    // small step from zero, then across the octant 0/1 boundary
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h1FFF_D000);
    cyc(0, 1, 0, 1, 32'h0000_1000);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0);
`ifndef PHASE_DITHER_EN
      if (i == 3) begin
        chk("t2_oct1", 32'(fold_oct), 1);
        chk("t2_ang1", 32'(fold_ang), 32'h1FFFF);
      end
`endif
    end

    // wrap from the top of octant 7
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_F000);
    cyc(0, 1, 0, 1, 32'h0000_1000);
    cyc(0, 1, 0, 0, 0);
`ifndef PHASE_DITHER_EN
    chk("t3_oct7", 32'(fold_oct), 7);
    chk("t3_ang0", 32'(fold_ang), 0);
`endif
    cyc(0, 1, 0, 0, 0);

    // clear has priority over en and suppresses the sample
    cyc(0, 1, 1, 0, 0);
    chk("t4_no_valid", 32'(fold_valid), 0);
    cyc(0, 1, 0, 0, 0);
    chk("t4_oct", 32'(fold_oct), 0);
`ifndef PHASE_DITHER_EN
    chk("t4_ang", 32'(fold_ang), 0);
`endif

    // bubbles and mid-pattern fcw change through the delay line
    cyc(0, 1, 0, 1, 32'h2000_0000);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h6000_0000);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < CORE_LAT + 3; i++) cyc(0, 0, 0, 0, 0);

    // reset mid-stream flushes the pipeline
    cyc(0, 0, 0, 1, 32'h3000_0000);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t6_fv", 32'(fold_valid), 0);
    chk("t6_pv", 32'(phi_r_valid), 0);
    for (int i = 0; i < CORE_LAT + 2; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t6_oct", 32'(fold_oct), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
          32'($urandom));
    end
    for (int i = 0; i < CORE_LAT + 2; i++) cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
